inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0, PC loaded at reset.
REQ-002 Parameter IDX_W, default 5, I-cache index width (2^IDX_W one-word lines).
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 rdy  input  1  global enable; low = hold all state.
REQ-006 jp_wrong  input  1  misprediction redirect from ROB.
REQ-007 jp_target  input  32  correct PC on jp_wrong.
REQ-008 stall_IF  input  1  decoder/ROB cannot accept an instruction.
REQ-009 ins_flag  output  1  ins/jp_flag/jp_pc valid this cycle.
REQ-010 ins  output  32  fetched instruction word.
REQ-011 jp_flag  output  1  fetch predicted taken for this instruction.
REQ-012 jp_pc  output  32  PC of this instruction.
REQ-013 mem_req  output  1  word read request to memory controller.
REQ-014 mem_addr  output  32  word-aligned read address.
REQ-015 mem_done  input  1  one-cycle pulse, mem_data valid.
REQ-016 mem_data  input  32  returned word.

Function
REQ-017 States SHALL be IDLE, MISS, DISCARD.
REQ-018 I-cache SHALL be direct-mapped: index pc[IDX_W+1:2], tag pc[31:IDX_W+2], one valid bit per line.
REQ-019 Priority each edge SHALL be: reset > jp_wrong > !rdy (hold) > stall_IF > fetch.
REQ-020 IDLE, hit, no stall: next cycle ins_flag=1, ins=line, jp_pc=pc, jp_flag=prediction, pc<=predicted next PC (1-cycle hit latency).
REQ-021 IDLE, miss, no stall: ins_flag<=0, mem_req<=1, mem_addr<=pc, go MISS.
REQ-022 MISS: mem_req held 1 until mem_done; on mem_done write line (data, tag, valid=1), mem_req<=0, go IDLE; instruction issues on next hit (miss penalty = mem latency + 2).
REQ-023 Prediction: opcode 1101111 (JAL) taken, next=pc+J-imm; opcode 1100011 with ins[31]=1 taken, next=pc+B-imm; all else (incl. JALR) not taken, next=pc+4; adds modulo 2^32.
REQ-024 stall_IF=1 in IDLE: ins_flag<=0, pc and outputs other than ins_flag held, no cache lookup consumed.
REQ-025 ins_flag SHALL be 1 for exactly one cycle per issued instruction; never two issues of the same PC without intervening redirect.
REQ-026 jp_wrong in any state: pc<=jp_target, ins_flag<=0, jp_flag<=0; in MISS go DISCARD, else IDLE.
REQ-027 DISCARD: mem_req<=0; on mem_done fill line (address still valid), go IDLE; further jp_wrong in DISCARD only updates pc.
REQ-028 jp_wrong coincident with mem_done in MISS: fill line, pc<=jp_target, go IDLE.
REQ-029 rdy=0: no register changes except mem_done fill, which SHALL still be captured.

Reset
REQ-030 Asserted rst: pc=RESET_PC, state=IDLE, all valid bits 0, ins_flag=0, ins=0, jp_flag=0, jp_pc=0, mem_req=0, mem_addr=0.
REQ-031 Reset mid-MISS: request abandoned; late mem_done after reset release in IDLE SHALL be ignored.

Structure
REQ-032 Opcode constants (JAL, BRANCH) and state encodings SHALL live in the shared defines file.
REQ-033 I-cache storage/lookup SHALL be sub-module icache (read index/tag -> hit, data; write port).
REQ-034 Predictor and next-PC adder SHALL be combinational inside inst_fetch.

Verification
REQ-035 Reset, RESET_PC=0, mem returns 32'h00000013 after 3 cycles -> mem_req@0, then ins_flag=1, ins=32'h13, jp_pc=0, jp_flag=0; next fetch addr 4.
REQ-036 Loop at 0x10: word 32'hFE000EE3 (beq x0,x0,-4) cached -> jp_flag=1, subsequent fetch pc=0x0C, second pass hits with no mem_req.
REQ-037 JAL 32'h0080006F at 0x20 -> jp_flag=1, next pc=0x28.
REQ-038 stall_IF high 4 cycles during hit stream -> ins_flag=0 throughout, resumes with same pending PC, no skipped/duplicated jp_pc.
REQ-039 jp_wrong, jp_target=0x100 during MISS for 0x40 -> DISCARD, mem_req drops, line 0x40 filled, next mem_req addr 0x100.
REQ-040 rst low during MISS, then stray mem_done -> cache all invalid, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: word width, predicted
// opcodes and the fetch FSM state encoding.
package inst_fetch_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MISS    = 2'd1,
      ST_DISCARD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/inst_fetch_icache.sv
// Direct-mapped instruction cache with one-word lines.
// The read port is asynchronous and the fill port is synchronous.
module icache
   import inst_fetch_pkg::*;
#(
   parameter int IDX_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [29:0]     i_rd_word,
   output logic            o_hit,
   output logic [XLEN-1:0] o_rd_data,
   input  logic            i_wr_en,
   input  logic [29:0]     i_wr_word,
   input  logic [XLEN-1:0] i_wr_data
);

   localparam int DEPTH = 2 ** IDX_W;
   localparam int TAG_W = 30 - IDX_W;

   logic [XLEN-1:0]  r_data [DEPTH];
   logic [TAG_W-1:0] r_tag  [DEPTH];
   logic [DEPTH-1:0] r_valid;

   logic [IDX_W-1:0] w_rd_idx;
   logic [TAG_W-1:0] w_rd_tag;
   logic [IDX_W-1:0] w_wr_idx;
   logic [TAG_W-1:0] w_wr_tag;

   assign w_rd_idx = i_rd_word[IDX_W-1:0];
   assign w_rd_tag = i_rd_word[29:IDX_W];
   assign w_wr_idx = i_wr_word[IDX_W-1:0];
   assign w_wr_tag = i_wr_word[29:IDX_W];

   assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
   assign o_rd_data = r_data[w_rd_idx];

   // NOTE: only the valid bits need reset; data and tag are never read
   // while their valid bit is clear, so they stay plain storage.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_data[w_wr_idx] <= i_wr_data;
         r_tag[w_wr_idx]  <= w_wr_tag;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
      end else if (i_wr_en) begin
         r_valid[w_wr_idx] <= 1'b1;
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC register, I-cache lookup, static branch prediction
// and a miss FSM that issues one-word reads to the memory controller.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0,
   parameter int              IDX_W    = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            rdy,
   input  logic            jp_wrong,
   input  logic [XLEN-1:0] jp_target,
   input  logic            stall_IF,
   output logic            ins_flag,
   output logic [XLEN-1:0] ins,
   output logic            jp_flag,
   output logic [XLEN-1:0] jp_pc,
   output logic            mem_req,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_done,
   input  logic [XLEN-1:0] mem_data
);

   fetch_state_e r_state, w_next_state;

   logic [XLEN-1:0] r_pc;
   logic            r_ins_flag;
   logic [XLEN-1:0] r_ins;
   logic            r_jp_flag;
   logic [XLEN-1:0] r_jp_pc;
   logic            r_mem_req;
   logic [XLEN-1:0] r_mem_addr;

   logic            w_hit;
   logic [XLEN-1:0] w_rd_data;
   logic            w_taken;
   logic [XLEN-1:0] w_offset;
   logic [XLEN-1:0] w_next_pc;
   logic            w_lookup;
   logic            w_issue;
   logic            w_miss_start;
   logic            w_fill;
   logic            w_drop_req;

   icache #(.IDX_W(IDX_W)) u_icache (
      .clk       (clk),
      .rst       (rst),
      .i_rd_word (r_pc[31:2]),
      .o_hit     (w_hit),
      .o_rd_data (w_rd_data),
      .i_wr_en   (w_fill),
      .i_wr_word (r_mem_addr[31:2]),
      .i_wr_data (mem_data)
   );

   // Static prediction: JAL always taken, backward conditional branches taken.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_taken  = 1'b0;
      w_offset = 32'd4;
      if (w_rd_data[6:0] == OPC_JAL) begin
         w_taken  = 1'b1;
         w_offset = {{12{w_rd_data[31]}}, w_rd_data[19:12], w_rd_data[20],
                     w_rd_data[30:21], 1'b0};
      end else if (w_rd_data[6:0] == OPC_BRANCH && w_rd_data[31]) begin
         w_taken  = 1'b1;
         w_offset = {{20{w_rd_data[31]}}, w_rd_data[7], w_rd_data[30:25],
                     w_rd_data[11:8], 1'b0};
      end
   end

   assign w_next_pc = r_pc + w_offset;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ST_IDLE:    if (w_miss_start) w_next_state = ST_MISS;
         ST_MISS:    if (mem_done)      w_next_state = ST_IDLE;
                     else if (jp_wrong) w_next_state = ST_DISCARD;
         ST_DISCARD: if (mem_done)      w_next_state = ST_IDLE;
         default:    w_next_state = ST_IDLE;
      endcase
   end

   // A fill completes the outstanding read even when rdy is low or a redirect lands.
   always_comb begin
      w_lookup     = (r_state == ST_IDLE) && !jp_wrong && rdy && !stall_IF;
      w_issue      = w_lookup && w_hit;
      w_miss_start = w_lookup && !w_hit;
      w_fill       = (r_state != ST_IDLE) && mem_done;
      w_drop_req   = w_fill || ((r_state == ST_MISS) && jp_wrong);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc       <= RESET_PC;
         r_ins_flag <= 1'b0;
         r_ins      <= '0;
         r_jp_flag  <= 1'b0;
         r_jp_pc    <= '0;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
      end else begin
         if (jp_wrong) begin
            r_pc       <= jp_target;
            r_ins_flag <= 1'b0;
            r_jp_flag  <= 1'b0;
         end else if (rdy) begin
            r_ins_flag <= w_issue;
            if (w_issue) begin
               r_ins     <= w_rd_data;
               r_jp_pc   <= r_pc;
               r_jp_flag <= w_taken;
               r_pc      <= w_next_pc;
            end
         end

         if (w_miss_start) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= {r_pc[31:2], 2'b00};
         end else if (w_drop_req) begin
            r_mem_req  <= 1'b0;
         end
      end
   end

   assign ins_flag = r_ins_flag;
   assign ins      = r_ins;
   assign jp_flag  = r_jp_flag;
   assign jp_pc    = r_jp_pc;
   assign mem_req  = r_mem_req;
   assign mem_addr = r_mem_addr;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a fixed-latency memory responder.
module tb_inst_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        rdy = 1'b1;
   logic        jp_wrong = 1'b0;
   logic [31:0] jp_target = '0;
   logic        stall_IF = 1'b0;
   logic        ins_flag;
   logic [31:0] ins;
   logic        jp_flag;
   logic [31:0] jp_pc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_done = 1'b0;
   logic [31:0] mem_data = '0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   inst_fetch #(.RESET_PC(32'h0), .IDX_W(5)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .jp_wrong(jp_wrong), .jp_target(jp_target),
      .stall_IF(stall_IF), .ins_flag(ins_flag), .ins(ins), .jp_flag(jp_flag),
      .jp_pc(jp_pc), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_done(mem_done), .mem_data(mem_data)
   );

   // Memory: 3-negedge latency after it first sees mem_req; manual mode when disabled.
   logic        resp_en = 1'b1;
   logic        resp_busy = 1'b0;
   int          resp_cnt = 0;
   logic [31:0] resp_addr = '0;
   logic        man_done = 1'b0;
   logic [31:0] man_data = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h10:  return 32'hFE000EE3;
         32'h20:  return 32'h0080006F;
         default: return 32'h00000013;
      endcase
   endfunction

   always @(negedge clk) begin
      mem_done = 1'b0;
      if (!resp_en) begin
         resp_busy = 1'b0;
         mem_done  = man_done;
         mem_data  = man_data;
      end else if (resp_busy) begin
         if (resp_cnt == 1) begin
            mem_done  = 1'b1;
            mem_data  = mem_word(resp_addr);
            resp_busy = 1'b0;
         end else begin
            resp_cnt = resp_cnt - 1;
         end
      end else if (mem_req) begin
         resp_busy = 1'b1;
         resp_addr = mem_addr;
         resp_cnt  = 3;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_issue(input int max_cycles, output bit found);
      found = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         tick();
         if (ins_flag === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) tick();
      checks++; if (ins_flag !== 1'b0) begin errors++; $display("FAIL rst_ins_flag got=%0b exp=0", ins_flag); end
      checks++; if (ins !== 32'h0) begin errors++; $display("FAIL rst_ins got=%h exp=0", ins); end
      checks++; if (jp_flag !== 1'b0) begin errors++; $display("FAIL rst_jp_flag got=%0b exp=0", jp_flag); end
      checks++; if (jp_pc !== 32'h0) begin errors++; $display("FAIL rst_jp_pc got=%h exp=0", jp_pc); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got=%0b exp=0", mem_req); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
      rst = 1'b1;
   endtask

   task automatic test_cold_miss();
      bit found;
      tick();
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL cold_req got=%0b exp=1", mem_req); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL cold_addr got=%h exp=0", mem_addr); end
      wait_issue(20, found);
      checks++; if (found !== 1'b1) begin errors++; $display("FAIL cold_issue timeout got=%0b exp=1", found); end
      checks++; if (ins !== 32'h00000013) begin errors++; $display("FAIL cold_ins got=%h exp=00000013", ins); end
      checks++; if (jp_pc !== 32'h0) begin errors++; $display("FAIL cold_jp_pc got=%h exp=0", jp_pc); end
      checks++; if (jp_flag !== 1'b0) begin errors++; $display("FAIL cold_jp_flag got=%0b exp=0", jp_flag); end
      tick();
      checks++; if (ins_flag !== 1'b0) begin errors++; $display("FAIL cold_one_cycle got=%0b exp=0", ins_flag); end
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin errors++; $display("FAIL cold_next_fetch got req=%0b addr=%h exp req=1 addr=4", mem_req, mem_addr); end
   endtask

   task automatic test_loop();
      bit found;
      logic [31:0] exp_pc [4];
      exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC; exp_pc[3] = 32'h10;
      for (int k = 0; k < 4; k++) begin
         wait_issue(20, found);
         checks++; if (found !== 1'b1 || jp_pc !== exp_pc[k]) begin errors++; $display("FAIL loop_pc%0d got found=%0b pc=%h exp pc=%h", k, found, jp_pc, exp_pc[k]); end
         checks++; if (jp_flag !== (k == 3)) begin errors++; $display("FAIL loop_flag%0d got=%0b exp=%0b", k, jp_flag, (k == 3)); end
      end
      checks++; if (ins !== 32'hFE000EE3) begin errors++; $display("FAIL loop_ins got=%h exp=FE000EE3", ins); end
      tick();
      checks++; if (ins_flag !== 1'b1 || jp_pc !== 32'hC || mem_req !== 1'b0) begin errors++; $display("FAIL loop_back got flag=%0b pc=%h req=%0b exp 1/0000000c/0", ins_flag, jp_pc, mem_req); end
      tick();
      checks++; if (ins_flag !== 1'b1 || jp_pc !== 32'h10 || jp_flag !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL loop_second got flag=%0b pc=%h jp=%0b req=%0b exp 1/00000010/1/0", ins_flag, jp_pc, jp_flag, mem_req); end
   endtask

   task automatic test_stall();
      stall_IF = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (ins_flag !== 1'b0 || jp_pc !== 32'h10) begin errors++; $display("FAIL stall_hold%0d got flag=%0b pc=%h exp 0/00000010", k, ins_flag, jp_pc); end
      end
      stall_IF = 1'b0;
      tick();
      checks++; if (ins_flag !== 1'b1 || jp_pc !== 32'hC) begin errors++; $display("FAIL stall_resume got flag=%0b pc=%h exp 1/0000000c", ins_flag, jp_pc); end
      tick();
      checks++; if (ins_flag !== 1'b1 || jp_pc !== 32'h10) begin errors++; $display("FAIL stall_next got flag=%0b pc=%h exp 1/00000010", ins_flag, jp_pc); end
   endtask

   task automatic test_rdy_hold();
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (ins_flag !== 1'b1 || jp_pc !== 32'h10 || mem_req !== 1'b0) begin errors++; $display("FAIL rdy_hold%0d got flag=%0b pc=%h req=%0b exp 1/00000010/0", k, ins_flag, jp_pc, mem_req); end
      end
      rdy = 1'b1;
      tick();
      checks++; if (ins_flag !== 1'b1 || jp_pc !== 32'hC) begin errors++; $display("FAIL rdy_resume got flag=%0b pc=%h exp 1/0000000c", ins_flag, jp_pc); end
      tick();
      checks++; if (jp_pc !== 32'h10 || jp_flag !== 1'b1) begin errors++; $display("FAIL rdy_next got pc=%h jp=%0b exp 00000010/1", jp_pc, jp_flag); end
   endtask

   task automatic test_jal();
      bit found;
      jp_wrong = 1'b1; jp_target = 32'h20;
      tick();
      jp_wrong = 1'b0;
      checks++; if (ins_flag !== 1'b0 || jp_flag !== 1'b0) begin errors++; $display("FAIL redirect_clear got flag=%0b jp=%0b exp 0/0", ins_flag, jp_flag); end
      wait_issue(20, found);
      checks++; if (found !== 1'b1 || jp_pc !== 32'h20) begin errors++; $display("FAIL jal_pc got found=%0b pc=%h exp 00000020", found, jp_pc); end
      checks++; if (ins !== 32'h0080006F || jp_flag !== 1'b1) begin errors++; $display("FAIL jal_pred got ins=%h jp=%0b exp 0080006f/1", ins, jp_flag); end
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h28) begin errors++; $display("FAIL jal_target got req=%0b addr=%h exp 1/00000028", mem_req, mem_addr); end
      wait_issue(20, found);
      checks++; if (found !== 1'b1 || jp_pc !== 32'h28 || jp_flag !== 1'b0) begin errors++; $display("FAIL jal_after got pc=%h jp=%0b exp 00000028/0", jp_pc, jp_flag); end
   endtask

   task automatic test_discard();
      bit found;
      jp_wrong = 1'b1; jp_target = 32'h40;
      tick();
      jp_wrong = 1'b0;
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin errors++; $display("FAIL disc_miss got req=%0b addr=%h exp 1/00000040", mem_req, mem_addr); end
      jp_wrong = 1'b1; jp_target = 32'h100;
      tick();
      jp_wrong = 1'b0;
      checks++; if (mem_req !== 1'b0 || ins_flag !== 1'b0) begin errors++; $display("FAIL disc_drop got req=%0b flag=%0b exp 0/0", mem_req, ins_flag); end
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (mem_req === 1'b1) begin found = 1'b1; break; end
      end
      checks++; if (found !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL disc_next_req got found=%0b addr=%h exp 00000100", found, mem_addr); end
      wait_issue(20, found);
      checks++; if (found !== 1'b1 || jp_pc !== 32'h100) begin errors++; $display("FAIL disc_issue got found=%0b pc=%h exp 00000100", found, jp_pc); end
      jp_wrong = 1'b1; jp_target = 32'h40;
      tick();
      jp_wrong = 1'b0;
      tick();
      checks++; if (ins_flag !== 1'b1 || jp_pc !== 32'h40 || ins !== 32'h13 || mem_req !== 1'b0) begin errors++; $display("FAIL disc_filled got flag=%0b pc=%h ins=%h req=%0b exp 1/00000040/00000013/0", ins_flag, jp_pc, ins, mem_req); end
   endtask

   task automatic test_reset_mid_miss();
      bit found;
      resp_en = 1'b0;
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin errors++; $display("FAIL rmm_miss got req=%0b addr=%h exp 1/00000044", mem_req, mem_addr); end
      tick();
      rst = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || ins_flag !== 1'b0 || jp_pc !== 32'h0) begin errors++; $display("FAIL rmm_async got req=%0b flag=%0b pc=%h exp 0/0/0", mem_req, ins_flag, jp_pc); end
      tick();
      man_done = 1'b1; man_data = 32'hDEADBEEF;
      rst = 1'b1;
      tick();
      man_done = 1'b0;
      resp_en = 1'b1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL rmm_restart got req=%0b addr=%h exp 1/0", mem_req, mem_addr); end
      wait_issue(20, found);
      checks++; if (found !== 1'b1 || jp_pc !== 32'h0 || ins !== 32'h13) begin errors++; $display("FAIL rmm_issue got found=%0b pc=%h ins=%h exp 0/00000013", found, jp_pc, ins); end
      tick();
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4) begin errors++; $display("FAIL rmm_invalid got req=%0b addr=%h exp 1/00000004", mem_req, mem_addr); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_cold_miss();
      test_loop();
      test_stall();
      test_rdy_hold();
      test_jal();
      test_discard();
      test_reset_mid_miss();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
